// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: independent round-robin A/B arbitration of the RF SRAM write and read ports.
// Latency: grants and sram_* are combinational; read data/valid are registered one cycle after the grant.
// Backpressure: a requester holds its request until granted; under contention grants alternate. Optional RF_ARB_R0_PROTECT_EN blocks writes to register 0.
module rf_port_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_wreq,
    input  logic             b_wreq,
    input  logic [3:0]       a_waddr,
    input  logic [3:0]       b_waddr,
    input  logic [15:0]      a_wdata,
    input  logic [15:0]      b_wdata,
    output logic             a_wgnt,
    output logic             b_wgnt,
    input  logic             a_rreq,
    input  logic             b_rreq,
    input  logic [3:0]       a_raddr,
    input  logic [3:0]       b_raddr,
    output logic             a_rgnt,
    output logic             b_rgnt,
    output logic             a_rvalid,
    output logic             b_rvalid,
    output logic [15:0]      a_rdata,
    output logic [15:0]      b_rdata,
    output logic             sram_we,
    output logic             sram_re,
    output logic [3:0]       sram_waddr,
    output logic [3:0]       sram_raddr,
    output logic [15:0]      sram_wdata,
    input  logic [15:0]      sram_rdata,
    output logic [CNT_W-1:0] wr_conflicts,
    output logic [CNT_W-1:0] rd_conflicts
`ifdef RF_ARB_R0_PROTECT_EN
    ,
    output logic             r0_wr_drop
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             wr_pri_q, rd_pri_q;
    logic             rd_vld_q, rd_owner_q;
    logic [15:0]      a_rdata_q, b_rdata_q;
    logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
    logic             wr_both, rd_both, wr_any, rd_any;

    assign wr_both = a_wreq & b_wreq;
    assign rd_both = a_rreq & b_rreq;

    // Pointer-favoured requester wins a contested port; reset masks every grant.
    assign a_wgnt = rst_n & a_wreq & ~(b_wreq &  wr_pri_q);
    assign b_wgnt = rst_n & b_wreq & ~(a_wreq & ~wr_pri_q);
    assign a_rgnt = rst_n & a_rreq & ~(b_rreq &  rd_pri_q);
    assign b_rgnt = rst_n & b_rreq & ~(a_rreq & ~rd_pri_q);
    assign wr_any = a_wgnt | b_wgnt;
    assign rd_any = a_rgnt | b_rgnt;

    always_comb begin
        sram_waddr = 4'd0;
        sram_wdata = 16'd0;
        sram_raddr = 4'd0;
        if (a_wgnt) begin
            sram_waddr = a_waddr;
            sram_wdata = a_wdata;
        end else if (b_wgnt) begin
            sram_waddr = b_waddr;
            sram_wdata = b_wdata;
        end
        if (a_rgnt) begin
            sram_raddr = a_raddr;
        end else if (b_rgnt) begin
            sram_raddr = b_raddr;
        end
    end

`ifdef RF_ARB_R0_PROTECT_EN
    logic r0_hit, r0_drop_q;
    // The requester is still released, only the SRAM write strobe is suppressed.
    assign r0_hit     = wr_any & (sram_waddr == 4'd0);
    assign sram_we    = wr_any & ~r0_hit;
    assign r0_wr_drop = r0_drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_drop_q <= 1'b0;
        end else begin
            r0_drop_q <= r0_hit;
        end
    end
`else
    assign sram_we = wr_any;
`endif

    assign sram_re      = rd_any;
    assign a_rvalid     = rd_vld_q & ~rd_owner_q;
    assign b_rvalid     = rd_vld_q &  rd_owner_q;
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign wr_conflicts = wr_cnt_q;
    assign rd_conflicts = rd_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pri_q   <= 1'b0;
            rd_pri_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_owner_q <= 1'b0;
            a_rdata_q  <= 16'd0;
            b_rdata_q  <= 16'd0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            // After a contested cycle the loser becomes favoured.
            if (wr_both) wr_pri_q <= ~wr_pri_q;
            if (rd_both) rd_pri_q <= ~rd_pri_q;
            if (wr_both && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_ONE;
            if (rd_both && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_ONE;
            rd_vld_q   <= rd_any;
            rd_owner_q <= b_rgnt;
            // SRAM already presented the granted word on the intervening negedge.
            if (a_rgnt) a_rdata_q <= sram_rdata;
            if (b_rgnt) b_rdata_q <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter with a negedge-committing SRAM model and a read-return scoreboard.
module tb_rf_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_wreq, b_wreq, a_rreq, b_rreq;
    logic [3:0]  a_waddr, b_waddr, a_raddr, b_raddr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_wgnt, b_wgnt, a_rgnt, b_rgnt, a_rvalid, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic        sram_we, sram_re;
    logic [3:0]  sram_waddr, sram_raddr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata = 16'd0;
    logic [7:0]  wr_conflicts, rd_conflicts;

    logic        d2_a_wgnt, d2_b_wgnt, d2_a_rgnt, d2_b_rgnt, d2_a_rvalid, d2_b_rvalid;
    logic [15:0] d2_a_rdata, d2_b_rdata, d2_sram_wdata;
    logic        d2_sram_we, d2_sram_re;
    logic [3:0]  d2_sram_waddr, d2_sram_raddr;
    logic [1:0]  d2_wr_conflicts, d2_rd_conflicts;
`ifdef RF_ARB_R0_PROTECT_EN
    logic        r0_wr_drop, d2_r0_wr_drop;
`endif

    always #5 clk = ~clk;

    rf_port_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_wreq(a_wreq), .b_wreq(b_wreq), .a_waddr(a_waddr), .b_waddr(b_waddr),
        .a_wdata(a_wdata), .b_wdata(b_wdata), .a_wgnt(a_wgnt), .b_wgnt(b_wgnt),
        .a_rreq(a_rreq), .b_rreq(b_rreq), .a_raddr(a_raddr), .b_raddr(b_raddr),
        .a_rgnt(a_rgnt), .b_rgnt(b_rgnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata), .sram_we(sram_we), .sram_re(sram_re),
        .sram_waddr(sram_waddr), .sram_raddr(sram_raddr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .wr_conflicts(wr_conflicts), .rd_conflicts(rd_conflicts)
`ifdef RF_ARB_R0_PROTECT_EN
        , .r0_wr_drop(r0_wr_drop)
`endif
    );

    rf_port_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .a_wreq(a_wreq), .b_wreq(b_wreq), .a_waddr(a_waddr), .b_waddr(b_waddr),
        .a_wdata(a_wdata), .b_wdata(b_wdata), .a_wgnt(d2_a_wgnt), .b_wgnt(d2_b_wgnt),
        .a_rreq(a_rreq), .b_rreq(b_rreq), .a_raddr(a_raddr), .b_raddr(b_raddr),
        .a_rgnt(d2_a_rgnt), .b_rgnt(d2_b_rgnt), .a_rvalid(d2_a_rvalid), .b_rvalid(d2_b_rvalid),
        .a_rdata(d2_a_rdata), .b_rdata(d2_b_rdata), .sram_we(d2_sram_we), .sram_re(d2_sram_re),
        .sram_waddr(d2_sram_waddr), .sram_raddr(d2_sram_raddr), .sram_wdata(d2_sram_wdata),
        .sram_rdata(sram_rdata), .wr_conflicts(d2_wr_conflicts), .rd_conflicts(d2_rd_conflicts)
`ifdef RF_ARB_R0_PROTECT_EN
        , .r0_wr_drop(d2_r0_wr_drop)
`endif
    );

    // SRAM model: read and write both commit on the falling edge, read sees the old word.
    logic [15:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 16'd0;
    always @(negedge clk) begin
        if (sram_re) sram_rdata <= mem[sram_raddr];
        if (sram_we) mem[sram_waddr] <= sram_wdata;
    end

    typedef struct {
        int          due;
        logic [15:0] d;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   cyc_n = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic push_a(input logic [15:0] d);
        exp_t e;
        e.due = cyc_n + 1;
        e.d   = d;
        exp_a.push_back(e);
    endtask

    task automatic push_b(input logic [15:0] d);
        exp_t e;
        e.due = cyc_n + 1;
        e.d   = d;
        exp_b.push_back(e);
    endtask

    // Scoreboard: a read return is due exactly one cycle after its grant; anything else is unexpected.
    always @(posedge clk) begin
        cyc_n++;
        #1;
        n_cmp++;
        if (exp_a.size() > 0 && exp_a[0].due == cyc_n) begin
            if (a_rvalid !== 1'b1 || a_rdata !== exp_a[0].d) begin
                n_err++;
                $display("FAIL a_read_return cyc %0d: rvalid=%b rdata=%h, want rvalid=1 rdata=%h",
                         cyc_n, a_rvalid, a_rdata, exp_a[0].d);
            end
            void'(exp_a.pop_front());
        end else if (a_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL a_rvalid_unexpected cyc %0d: rvalid=%b, want 0", cyc_n, a_rvalid);
        end
        n_cmp++;
        if (exp_b.size() > 0 && exp_b[0].due == cyc_n) begin
            if (b_rvalid !== 1'b1 || b_rdata !== exp_b[0].d) begin
                n_err++;
                $display("FAIL b_read_return cyc %0d: rvalid=%b rdata=%h, want rvalid=1 rdata=%h",
                         cyc_n, b_rvalid, b_rdata, exp_b[0].d);
            end
            void'(exp_b.pop_front());
        end else if (b_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL b_rvalid_unexpected cyc %0d: rvalid=%b, want 0", cyc_n, b_rvalid);
        end
    end

    // Inputs change 2 time units after the rising edge; combinational checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_all();
        a_wreq = 0; b_wreq = 0; a_rreq = 0; b_rreq = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        a_wreq = 1; b_wreq = 1; a_rreq = 1; b_rreq = 1;
        a_waddr = 4'd1; a_wdata = 16'h0101; b_waddr = 4'd2; b_wdata = 16'h0202;
        a_raddr = 4'd9; b_raddr = 4'd10;
        #1;
        n_cmp++;
        if ({a_wgnt, b_wgnt, a_rgnt, b_rgnt, sram_we, sram_re} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_grants: %b, want 000000", {a_wgnt, b_wgnt, a_rgnt, b_rgnt, sram_we, sram_re});
        end
        tick();
        n_cmp++;
        if (wr_conflicts !== 8'd0 || rd_conflicts !== 8'd0) begin
            n_err++;
            $display("FAIL reset_counters: wr=%0d rd=%0d, want 0 0", wr_conflicts, rd_conflicts);
        end
        rst_n = 1; a_rreq = 0; b_rreq = 0;
        #1;
        n_cmp++;
        if (a_wgnt !== 1'b1 || b_wgnt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_wgnt: a=%b b=%b, want a=1 b=0", a_wgnt, b_wgnt);
        end
        tick();
        a_rreq = 1; b_rreq = 1;
        #1;
        n_cmp++;
        if (a_wgnt !== 1'b0 || b_wgnt !== 1'b1 || a_rgnt !== 1'b1 || b_rgnt !== 1'b0 || wr_conflicts !== 8'd1) begin
            n_err++;
            $display("FAIL pre_reset_traffic: wgnt a=%b b=%b rgnt a=%b b=%b wrc=%0d, want 0 1 1 0 1",
                     a_wgnt, b_wgnt, a_rgnt, b_rgnt, wr_conflicts);
        end
        rst_n = 0;
        #1;
        n_cmp++;
        if ({a_wgnt, b_wgnt, a_rgnt, b_rgnt, sram_we, sram_re} !== 6'b0 || wr_conflicts !== 8'd0) begin
            n_err++;
            $display("FAIL midtraffic_reset: ctl=%b wrc=%0d, want 000000 0",
                     {a_wgnt, b_wgnt, a_rgnt, b_rgnt, sram_we, sram_re}, wr_conflicts);
        end
        tick();
        rst_n = 1; a_rreq = 0; b_rreq = 0;
        #1;
        n_cmp++;
        if (a_wgnt !== 1'b1 || b_wgnt !== 1'b0) begin
            n_err++;
            $display("FAIL pointer_cleared: a=%b b=%b, want a=1 b=0", a_wgnt, b_wgnt);
        end
        tick();
        idle_all();
    endtask

    task automatic test_single_wr_rd();
        tick();
        a_wreq = 1; a_waddr = 4'd5; a_wdata = 16'hBEEF;
        #1;
        n_cmp++;
        if (a_wgnt !== 1'b1 || sram_we !== 1'b1 || sram_waddr !== 4'd5 || sram_wdata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL single_write: gnt=%b we=%b addr=%h data=%h, want 1 1 5 beef",
                     a_wgnt, sram_we, sram_waddr, sram_wdata);
        end
        tick();
        a_wreq = 0; a_rreq = 1; a_raddr = 4'd5;
        push_a(16'hBEEF);
        #1;
        n_cmp++;
        if (a_rgnt !== 1'b1 || sram_re !== 1'b1 || sram_raddr !== 4'd5 || sram_we !== 1'b0 || sram_waddr !== 4'd0) begin
            n_err++;
            $display("FAIL single_read: rgnt=%b re=%b raddr=%h we=%b waddr=%h, want 1 1 5 0 0",
                     a_rgnt, sram_re, sram_raddr, sram_we, sram_waddr);
        end
        tick();
        idle_all();
    endtask

    task automatic test_contention();
        rst_n = 0;
        #1;
        rst_n = 1;
        a_wreq = 1; b_wreq = 1;
        a_waddr = 4'd7; a_wdata = 16'hA7A7; b_waddr = 4'd8; b_wdata = 16'hB8B8;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (a_wgnt !== (i % 2 == 0) || b_wgnt !== (i % 2 == 1)) begin
                n_err++;
                $display("FAIL contention_wgnt[%0d]: a=%b b=%b, want a=%b b=%b",
                         i, a_wgnt, b_wgnt, (i % 2 == 0), (i % 2 == 1));
            end
            tick();
        end
        idle_all();
        #1;
        n_cmp++;
        if (wr_conflicts !== 8'd4) begin
            n_err++;
            $display("FAIL wr_conflicts: %0d, want 4", wr_conflicts);
        end
    endtask

    task automatic test_saturation();
        tick();
        a_rreq = 1; b_rreq = 1; a_raddr = 4'd7; b_raddr = 4'd8;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push_a(16'hA7A7);
            else            push_b(16'hB8B8);
            #1;
            n_cmp++;
            if (a_rgnt !== (i % 2 == 0) || b_rgnt !== (i % 2 == 1)) begin
                n_err++;
                $display("FAIL contention_rgnt[%0d]: a=%b b=%b, want a=%b b=%b",
                         i, a_rgnt, b_rgnt, (i % 2 == 0), (i % 2 == 1));
            end
            tick();
        end
        idle_all();
        #1;
        n_cmp++;
        if (rd_conflicts !== 8'd6 || d2_rd_conflicts !== 2'd3) begin
            n_err++;
            $display("FAIL rd_conflicts: w8=%0d w2=%0d, want 6 3", rd_conflicts, d2_rd_conflicts);
        end
    endtask

    task automatic test_raw();
        tick();
        a_wreq = 1; a_waddr = 4'd3; a_wdata = 16'h1111;
        tick();
        a_wdata = 16'h2222;
        b_rreq = 1; b_raddr = 4'd3;
        push_b(16'h1111);
        #1;
        n_cmp++;
        if (a_wgnt !== 1'b1 || b_rgnt !== 1'b1 || sram_raddr !== 4'd3 || sram_wdata !== 16'h2222) begin
            n_err++;
            $display("FAIL raw_grants: wgnt=%b rgnt=%b raddr=%h wdata=%h, want 1 1 3 2222",
                     a_wgnt, b_rgnt, sram_raddr, sram_wdata);
        end
        tick();
        a_wreq = 0;
        push_b(16'h2222);
        tick();
        idle_all();
    endtask

    task automatic test_r0();
        tick();
        a_wreq = 1; a_waddr = 4'd0; a_wdata = 16'hFFFF;
        #1;
        n_cmp++;
`ifdef RF_ARB_R0_PROTECT_EN
        if (a_wgnt !== 1'b1 || sram_we !== 1'b0) begin
            n_err++;
            $display("FAIL r0_protect_write: wgnt=%b we=%b, want 1 0", a_wgnt, sram_we);
        end
`else
        if (a_wgnt !== 1'b1 || sram_we !== 1'b1) begin
            n_err++;
            $display("FAIL r0_passthrough_write: wgnt=%b we=%b, want 1 1", a_wgnt, sram_we);
        end
`endif
        tick();
        a_wreq = 0; a_rreq = 1; a_raddr = 4'd0;
`ifdef RF_ARB_R0_PROTECT_EN
        push_a(16'h0000);
        #1;
        n_cmp++;
        if (r0_wr_drop !== 1'b1) begin
            n_err++;
            $display("FAIL r0_wr_drop_pulse: %b, want 1", r0_wr_drop);
        end
`else
        push_a(16'hFFFF);
`endif
        tick();
        idle_all();
`ifdef RF_ARB_R0_PROTECT_EN
        #1;
        n_cmp++;
        if (r0_wr_drop !== 1'b0) begin
            n_err++;
            $display("FAIL r0_wr_drop_clear: %b, want 0", r0_wr_drop);
        end
`endif
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        a_waddr = 0; b_waddr = 0; a_raddr = 0; b_raddr = 0;
        a_wdata = 0; b_wdata = 0;
        test_reset();
        test_single_wr_rd();
        test_contention();
        test_saturation();
        test_raw();
        test_r0();
        tick();
        tick();
        n_cmp++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: a=%0d b=%0d left, want 0 0", exp_a.size(), exp_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Two-requester arbiter that shares the 16x16 dual-port register-file SRAM (one write port, one read port, both committed on the falling clock edge) between requester A (CPU datapath) and requester B (debug/UART loader). The read and write ports are arbitrated independently, each with its own round-robin pointer. Read data is registered and returned to the winning requester with a valid pulse. The block sits directly in front of the SRAM instance and drives all of its control inputs.

## Interface
Parameters:
- CNT_W, 8, width of the saturating conflict counters

Ports:
- clk  in  1  system clock; SRAM commits on negedge, this block registers on posedge
- rst_n  in  1  asynchronous active-low reset
- a_wreq, b_wreq  in  1  write request from A / B
- a_waddr, b_waddr  in  4  write address
- a_wdata, b_wdata  in  16  write data
- a_wgnt, b_wgnt  out  1  write grant; combinational, same cycle as request
- a_rreq, b_rreq  in  1  read request
- a_raddr, b_raddr  in  4  read address
- a_rgnt, b_rgnt  out  1  read grant; combinational
- a_rvalid, b_rvalid  out  1  registered read-data-valid pulse
- a_rdata, b_rdata  out  16  registered read data
- sram_we, sram_re  out  1  to SRAM we / re
- sram_waddr, sram_raddr  out  4  to SRAM
- sram_wdata  out  16  to SRAM
- sram_rdata  in  16  from SRAM rdata
- wr_conflicts, rd_conflicts  out  CNT_W  saturating counts of cycles where both requesters asked for the same port

## Operation
- Each port has a 1-bit priority pointer: wr_pri, rd_pri (0 = A favoured, 1 = B favoured).
- Grant rule per port: only one requester asks -> it wins; both ask -> the pointer-favoured one wins; neither asks -> no grant.
- Pointer update at posedge: after a contested cycle, the pointer moves to the loser. Uncontested cycles leave the pointer unchanged.
- Write grant: sram_we=1; sram_waddr/sram_wdata are muxed from the winner in the same cycle. With no grant, sram_we=0 and the address/data outputs are driven to 0.
- Read grant: sram_re=1; sram_raddr is muxed from the winner. A 1-bit rd_owner register captures the winner at posedge.
- Read return: at the posedge following the grant, sram_rdata (valid since the intervening negedge) is captured into the owner's rdata register, and the owner's rvalid goes high for exactly one cycle. The non-owner's rdata holds its previous value.
- Requester rule: hold req, addr and data stable until the grant is seen. A requester drops req or changes addr in the cycle after its grant. Back-to-back grants to the same requester are legal.
- Same-address read and write in one cycle: the read returns the pre-write value, because the SRAM commits both on the same negedge.
- Conflict counters increment on each contested cycle and saturate at 2^CNT_W-1.
- Asynchronous reset takes effect immediately:
  - pointers cleared to 0; all rvalid, rdata, rd_owner and counters cleared to 0.
  - All grants and sram_we/sram_re are forced to 0 while rst_n=0.
  - A read granted in the cycle reset asserts never produces rvalid.

## Timing
- Write latency: grant in cycle N; data is in the SRAM after the negedge of cycle N and is readable by a grant in cycle N+1.
- Read latency: grant in cycle N; rvalid and rdata are valid in cycle N+1, one cycle.
- Throughput: one write and one read per cycle aggregate. Under continuous contention each requester gets every other cycle.
- All outputs except grants and sram_* controls are registered. Grants and sram_* are combinational from the req inputs, the pointers and rst_n.

## Configuration
- RF_ARB_R0_PROTECT_EN defined:
  - A granted write to address 0 still returns wgnt=1 (the requester is released), but sram_we is held 0 so register zero stays 0.
  - A 1-cycle registered output r0_wr_drop pulses in cycle N+1.
- RF_ARB_R0_PROTECT_EN undefined: r0_wr_drop does not exist and writes to address 0 pass through unchanged.

## Test plan
- Reset: assert rst_n=0 mid-traffic -> all grants, sram_we/sram_re, rvalid and counters are 0 immediately; after release, wr_pri=rd_pri=0.
- Single write then read: A writes 0xBEEF to addr 5 in cycle 1, reads addr 5 in cycle 2 -> a_rvalid=1 and a_rdata=0xBEEF in cycle 3; b_rvalid stays 0.
- Contention: A and B hold wreq continuously for 4 cycles -> grants go A,B,A,B; wr_conflicts=4.
- Same-cycle RAW: addr 3 holds 0x1111; A writes 0x2222 to addr 3 while B reads addr 3 -> b_rdata=0x1111 next cycle; a read one cycle later returns 0x2222.
- Saturation: CNT_W=2 with 6 contested read cycles -> rd_conflicts=3.
- R0 protect (macro on): A writes 0xFFFF to addr 0 -> a_wgnt=1, sram_we=0, r0_wr_drop pulses next cycle, and a read of addr 0 returns 0x0000. With the macro off, sram_we=1.
